stage_id_pipe: RTL and testbench



---
 rtl/stage_id_pipe.sv | 186 ++++++++++++++++++
 tb/tb_stage_id_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_id_pipe.sv
// Instruction-decode stage with built-in ID/EX pipeline register.
// Holds the register file (optional write-through bypass) and the control decoder.
// Detects load-use hazards and inserts a bubble for them, handles flush,
// and keeps a saturating count of stall cycles.
//
// Control decode (opcode -> controls):
//   R-type 0x00 : RegWr RegDst R_type,       ALUop 100
//   j      0x02 : Jump,                       ALUop 000
//   beq    0x04 : Branch,                     ALUop 001
//   addiu  0x09 : RegWr ALUSrc ExtOp,         ALUop 000
//   ori    0x0d : RegWr ALUSrc,               ALUop 010
//   lw     0x23 : RegWr ALUSrc ExtOp MemtoReg, ALUop 000
//   sw     0x2b : ALUSrc ExtOp MemWr,         ALUop 000
//   any other opcode decodes to all controls 0.
module stage_id_pipe #(
  parameter int DW     = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  parameter int CNTW   = 16,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            IDin_Valid,
  input  logic [DW-1:0]   IDin_PC4,
  input  logic [31:0]     IDin_Inst,
  input  logic            Flush,
  input  logic            WR_RegWE,
  input  logic [AW-1:0]   WR_Rw,
  input  logic [DW-1:0]   WR_RegDin,
  output logic            IDout_Stall,
  output logic            IDout_Valid,
  output logic [DW-1:0]   IDout_PC4,
  output logic [DW-1:0]   IDout_Jtarg,
  output logic [DW-1:0]   IDout_busA,
  output logic [DW-1:0]   IDout_busB,
  output logic [AW-1:0]   IDout_Rt,
  output logic [AW-1:0]   IDout_Rd,
  output logic [AW-1:0]   IDout_Rw,
  output logic [5:0]      IDout_func,
  output logic [15:0]     IDout_immd,
  output logic            IDout_RegWr,
  output logic            IDout_ALUSrc,
  output logic            IDout_RegDst,
  output logic            IDout_MemtoReg,
  output logic            IDout_MemWr,
  output logic            IDout_Branch,
  output logic            IDout_Jump,
  output logic            IDout_ExtOp,
  output logic            IDout_R_type,
  output logic [2:0]      IDout_ALUop,
  output logic [CNTW-1:0] StallCnt
);

  logic [5:0]    op;
  logic [AW-1:0] rs, rt, rd;
  logic [DW-1:0] jtarg;

  assign op = IDin_Inst[31:26];
  assign rs = IDin_Inst[21 +: AW];
  assign rt = IDin_Inst[16 +: AW];
  assign rd = IDin_Inst[11 +: AW];

  // Jump target keeps the upper PC4 bits above bit 27.
  always_comb begin
    jtarg       = IDin_PC4;
    jtarg[27:0] = {IDin_Inst[25:0], 2'b00};
  end

  logic       d_regwr, d_alusrc, d_regdst, d_memtoreg, d_memwr;
  logic       d_branch, d_jump, d_extop, d_rtype;
  logic [2:0] d_aluop;

  // Control decoder.
  always_comb begin
    d_regwr    = 1'b0;
    d_alusrc   = 1'b0;
    d_regdst   = 1'b0;
    d_memtoreg = 1'b0;
    d_memwr    = 1'b0;
    d_branch   = 1'b0;
    d_jump     = 1'b0;
    d_extop    = 1'b0;
    d_rtype    = (op == 6'h00);
    d_aluop    = 3'b000;
    case (op)
      6'h00: begin d_regwr = 1'b1; d_regdst = 1'b1; d_aluop = 3'b100; end
      6'h02: begin d_jump = 1'b1; end
      6'h04: begin d_branch = 1'b1; d_aluop = 3'b001; end
      6'h09: begin d_regwr = 1'b1; d_alusrc = 1'b1; d_extop = 1'b1; end
      6'h0d: begin d_regwr = 1'b1; d_alusrc = 1'b1; d_aluop = 3'b010; end
      6'h23: begin d_regwr = 1'b1; d_alusrc = 1'b1; d_extop = 1'b1; d_memtoreg = 1'b1; end
      6'h2b: begin d_alusrc = 1'b1; d_extop = 1'b1; d_memwr = 1'b1; end
      default: ;
    endcase
  end

  logic [DW-1:0] regs [NREG];
  logic          wr_en;
  logic [DW-1:0] rd_a, rd_b;

  assign wr_en = WR_RegWE && (WR_Rw != '0);

  // Register file write; entry 0 is never written so it stays zero from reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[WR_Rw] <= WR_RegDin;
    end
  end

  // Read ports; a same-cycle write is forwarded when bypass is enabled.
  always_comb begin
    rd_a = regs[rs];
    rd_b = regs[rt];
    if (rs == '0)                                 rd_a = '0;
    else if (BYPASS != 0 && wr_en && WR_Rw == rs) rd_a = WR_RegDin;
    if (rt == '0)                                 rd_b = '0;
    else if (BYPASS != 0 && wr_en && WR_Rw == rt) rd_b = WR_RegDin;
  end

  // A load still in ID/EX whose destination feeds this instruction must wait one cycle.
  logic hazard, take, ctl_en;
  assign hazard = IDin_Valid && IDout_Valid && IDout_MemtoReg && (IDout_Rw != '0) &&
                  ((IDout_Rw == rs) || (IDout_Rw == rt));
  assign IDout_Stall = hazard && !Flush;

  // take=0 loads a bubble (flush or stall); controls also require a valid input.
  assign take   = !(Flush || IDout_Stall);
  assign ctl_en = take && IDin_Valid;

  // ID/EX pipeline register; bubbles zero every field.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      IDout_Valid    <= 1'b0;
      IDout_PC4      <= '0;
      IDout_Jtarg    <= '0;
      IDout_busA     <= '0;
      IDout_busB     <= '0;
      IDout_Rt       <= '0;
      IDout_Rd       <= '0;
      IDout_Rw       <= '0;
      IDout_func     <= '0;
      IDout_immd     <= '0;
      IDout_RegWr    <= 1'b0;
      IDout_ALUSrc   <= 1'b0;
      IDout_RegDst   <= 1'b0;
      IDout_MemtoReg <= 1'b0;
      IDout_MemWr    <= 1'b0;
      IDout_Branch   <= 1'b0;
      IDout_Jump     <= 1'b0;
      IDout_ExtOp    <= 1'b0;
      IDout_R_type   <= 1'b0;
      IDout_ALUop    <= '0;
    end else begin
      IDout_Valid    <= ctl_en;
      IDout_PC4      <= take ? IDin_PC4 : '0;
      IDout_Jtarg    <= take ? jtarg : '0;
      IDout_busA     <= take ? rd_a : '0;
      IDout_busB     <= take ? rd_b : '0;
      IDout_Rt       <= take ? rt : '0;
      IDout_Rd       <= take ? rd : '0;
      IDout_Rw       <= take ? ((ctl_en && d_regdst) ? rd : rt) : '0;
      IDout_func     <= take ? IDin_Inst[5:0] : '0;
      IDout_immd     <= take ? IDin_Inst[15:0] : '0;
      IDout_RegWr    <= ctl_en && d_regwr;
      IDout_ALUSrc   <= ctl_en && d_alusrc;
      IDout_RegDst   <= ctl_en && d_regdst;
      IDout_MemtoReg <= ctl_en && d_memtoreg;
      IDout_MemWr    <= ctl_en && d_memwr;
      IDout_Branch   <= ctl_en && d_branch;
      IDout_Jump     <= ctl_en && d_jump;
      IDout_ExtOp    <= ctl_en && d_extop;
      IDout_R_type   <= ctl_en && d_rtype;
      IDout_ALUop    <= ctl_en ? d_aluop : 3'b000;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                              StallCnt <= '0;
    else if (IDout_Stall && (StallCnt != '1)) StallCnt <= StallCnt + 1'b1;
  end

endmodule

// File: tb/tb_stage_id_pipe.sv
// Directed bench for stage_id_pipe. Two instances share the inputs:
// a_* uses the defaults (bypass on, 16-bit counter), b_* has bypass off and a 2-bit counter.
module tb_stage_id_pipe;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        IDin_Valid;
  logic [31:0] IDin_PC4;
  logic [31:0] IDin_Inst;
  logic        Flush;
  logic        WR_RegWE;
  logic [4:0]  WR_Rw;
  logic [31:0] WR_RegDin;

  logic        a_stall, a_valid, a_regwr, a_alusrc, a_regdst, a_memtoreg, a_memwr;
  logic        a_branch, a_jump, a_extop, a_rtype;
  logic [31:0] a_pc4, a_jtarg, a_busa, a_busb;
  logic [4:0]  a_rt, a_rd, a_rw;
  logic [5:0]  a_func;
  logic [15:0] a_immd;
  logic [2:0]  a_aluop;
  logic [15:0] a_cnt;

  logic        b_stall, b_valid, b_regwr, b_alusrc, b_regdst, b_memtoreg, b_memwr;
  logic        b_branch, b_jump, b_extop, b_rtype;
  logic [31:0] b_pc4, b_jtarg, b_busa, b_busb;
  logic [4:0]  b_rt, b_rd, b_rw;
  logic [5:0]  b_func;
  logic [15:0] b_immd;
  logic [2:0]  b_aluop;
  logic [1:0]  b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] ADD_R3_R1_R2 = 32'h0022_1820;
  localparam logic [31:0] ADD_R3_R5_R0 = 32'h00A0_1820;
  localparam logic [31:0] ADD_R7_R0_R0 = 32'h0000_3820;
  localparam logic [31:0] J_100        = 32'h0800_0100;
  localparam logic [31:0] LW_R4_R1     = 32'h8C24_0000;
  localparam logic [31:0] ADD_R6_R4_R2 = 32'h0082_3020;
  localparam logic [31:0] LW_R4_R4     = 32'h8C84_0000;

  stage_id_pipe dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .IDin_Valid(IDin_Valid), .IDin_PC4(IDin_PC4),
    .IDin_Inst(IDin_Inst), .Flush(Flush), .WR_RegWE(WR_RegWE), .WR_Rw(WR_Rw),
    .WR_RegDin(WR_RegDin), .IDout_Stall(a_stall), .IDout_Valid(a_valid),
    .IDout_PC4(a_pc4), .IDout_Jtarg(a_jtarg), .IDout_busA(a_busa), .IDout_busB(a_busb),
    .IDout_Rt(a_rt), .IDout_Rd(a_rd), .IDout_Rw(a_rw), .IDout_func(a_func),
    .IDout_immd(a_immd), .IDout_RegWr(a_regwr), .IDout_ALUSrc(a_alusrc),
    .IDout_RegDst(a_regdst), .IDout_MemtoReg(a_memtoreg), .IDout_MemWr(a_memwr),
    .IDout_Branch(a_branch), .IDout_Jump(a_jump), .IDout_ExtOp(a_extop),
    .IDout_R_type(a_rtype), .IDout_ALUop(a_aluop), .StallCnt(a_cnt)
  );

  stage_id_pipe #(.BYPASS(0), .CNTW(2)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .IDin_Valid(IDin_Valid), .IDin_PC4(IDin_PC4),
    .IDin_Inst(IDin_Inst), .Flush(Flush), .WR_RegWE(WR_RegWE), .WR_Rw(WR_Rw),
    .WR_RegDin(WR_RegDin), .IDout_Stall(b_stall), .IDout_Valid(b_valid),
    .IDout_PC4(b_pc4), .IDout_Jtarg(b_jtarg), .IDout_busA(b_busa), .IDout_busB(b_busb),
    .IDout_Rt(b_rt), .IDout_Rd(b_rd), .IDout_Rw(b_rw), .IDout_func(b_func),
    .IDout_immd(b_immd), .IDout_RegWr(b_regwr), .IDout_ALUSrc(b_alusrc),
    .IDout_RegDst(b_regdst), .IDout_MemtoReg(b_memtoreg), .IDout_MemWr(b_memwr),
    .IDout_Branch(b_branch), .IDout_Jump(b_jump), .IDout_ExtOp(b_extop),
    .IDout_R_type(b_rtype), .IDout_ALUop(b_aluop), .StallCnt(b_cnt)
  );

  // Clock and global time limit.
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL timeout: observed=no_finish expected=finish");
    $fatal(1, "time limit");
  end

  // Advance one cycle; returns 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [31:0] pc4, input logic [31:0] inst,
                       input logic fl, input logic we, input logic [4:0] rw,
                       input logic [31:0] din);
    IDin_Valid = valid;
    IDin_PC4   = pc4;
    IDin_Inst  = inst;
    Flush      = fl;
    WR_RegWE   = we;
    WR_Rw      = rw;
    WR_RegDin  = din;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held with random inputs.
    Rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      tick();
    end
    chk("rst_valid",    {31'd0, a_valid},    32'd0);
    chk("rst_regwr",    {31'd0, a_regwr},    32'd0);
    chk("rst_memtoreg", {31'd0, a_memtoreg}, 32'd0);
    chk("rst_pc4",      a_pc4,               32'd0);
    chk("rst_busa",     a_busa,              32'd0);
    chk("rst_aluop",    {29'd0, a_aluop},    32'd0);
    chk("rst_cnt_a",    {16'd0, a_cnt},      32'd0);
    chk("rst_cnt_b",    {30'd0, b_cnt},      32'd0);
    chk("rst_stall",    {31'd0, a_stall},    32'd0);
    chk("rst_valid_b",  {31'd0, b_valid},    32'd0);

    // Release reset; first decode reads cleared registers.
    Rst_n = 1'b1;
    drive(1'b1, 32'h0000_0008, ADD_R3_R1_R2, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("add_valid",  {31'd0, a_valid},  32'd1);
    chk("add_busa",   a_busa,            32'd0);
    chk("add_busb",   a_busb,            32'd0);
    chk("add_rw",     {27'd0, a_rw},     32'd3);
    chk("add_regwr",  {31'd0, a_regwr},  32'd1);
    chk("add_regdst", {31'd0, a_regdst}, 32'd1);
    chk("add_rtype",  {31'd0, a_rtype},  32'd1);
    chk("add_aluop",  {29'd0, a_aluop},  32'd4);
    chk("add_pc4",    a_pc4,             32'h8);
    chk("add_func",   {26'd0, a_func},   32'h20);

    // Write-through: r5 written while add r3,r5,r0 decodes.
    drive(1'b1, 32'h0000_000C, ADD_R3_R5_R0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    chk("byp_busa_a", a_busa, 32'hDEAD_BEEF);
    chk("byp_busa_b", b_busa, 32'h0);
    chk("byp_busb_a", a_busb, 32'h0);

    // Written value visible next cycle in both instances.
    drive(1'b1, 32'h0000_0010, ADD_R3_R5_R0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("wr_busa_a", a_busa, 32'hDEAD_BEEF);
    chk("wr_busa_b", b_busa, 32'hDEAD_BEEF);

    // Register 0 write is ignored.
    drive(1'b1, 32'h0000_0014, ADD_R7_R0_R0, 1'b0, 1'b1, 5'd0, 32'h0000_1234);
    tick();
    chk("r0_busa_same", a_busa, 32'h0);
    drive(1'b1, 32'h0000_0018, ADD_R7_R0_R0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("r0_busa_next", a_busa, 32'h0);
    chk("r0_busb_next", b_busb, 32'h0);

    // Jump target keeps PC4 upper bits.
    drive(1'b1, 32'h4000_0004, J_100, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("j_jtarg", a_jtarg,           32'h4000_0400);
    chk("j_jump",  {31'd0, a_jump},   32'd1);
    chk("j_regwr", {31'd0, a_regwr},  32'd0);
    chk("j_rtype", {31'd0, a_rtype},  32'd0);

    // Load-use: lw r4,0(r1) then add r6,r4,r2.
    drive(1'b1, 32'h0000_0020, LW_R4_R1, 1'b0, 1'b0, 5'd0, 32'h0);
    #1 chk("lw_nostall", {31'd0, a_stall}, 32'd0);
    tick();
    chk("lw_memtoreg", {31'd0, a_memtoreg}, 32'd1);
    chk("lw_alusrc",   {31'd0, a_alusrc},   32'd1);
    chk("lw_extop",    {31'd0, a_extop},    32'd1);
    chk("lw_rw",       {27'd0, a_rw},       32'd4);
    drive(1'b1, 32'h0000_0024, ADD_R6_R4_R2, 1'b0, 1'b0, 5'd0, 32'h0);
    #1 chk("lu_stall", {31'd0, a_stall}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, a_valid},  32'd0);
    chk("lu_bubble_regwr", {31'd0, a_regwr},  32'd0);
    chk("lu_bubble_rtype", {31'd0, a_rtype},  32'd0);
    chk("lu_bubble_aluop", {29'd0, a_aluop},  32'd0);
    chk("lu_cnt_a",        {16'd0, a_cnt},    32'd1);
    chk("lu_cnt_b",        {30'd0, b_cnt},    32'd1);
    chk("lu_release",      {31'd0, a_stall},  32'd0);
    tick();
    chk("lu_issue_valid", {31'd0, a_valid}, 32'd1);
    chk("lu_issue_rw",    {27'd0, a_rw},    32'd6);
    chk("lu_issue_regwr", {31'd0, a_regwr}, 32'd1);
    chk("lu_cnt_hold",    {16'd0, a_cnt},   32'd1);

    // Flush in the same cycle as a load-use hazard.
    drive(1'b1, 32'h0000_0028, LW_R4_R1, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    drive(1'b1, 32'h0000_002C, ADD_R6_R4_R2, 1'b1, 1'b0, 5'd0, 32'h0);
    #1 chk("fl_stall", {31'd0, a_stall}, 32'd0);
    tick();
    chk("fl_valid", {31'd0, a_valid}, 32'd0);
    chk("fl_cnt_a", {16'd0, a_cnt},   32'd1);
    chk("fl_cnt_b", {30'd0, b_cnt},   32'd1);

    // Invalid input forces controls to zero.
    drive(1'b0, 32'h0000_0030, LW_R4_R1, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("inv_valid",    {31'd0, a_valid},    32'd0);
    chk("inv_memtoreg", {31'd0, a_memtoreg}, 32'd0);
    chk("inv_regwr",    {31'd0, a_regwr},    32'd0);
    chk("inv_alusrc",   {31'd0, a_alusrc},   32'd0);

    // Chained lw r4,0(r4): stalls every other cycle, 5 stalls in 10 cycles.
    drive(1'b1, 32'h0000_0034, LW_R4_R4, 1'b0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1 chk($sformatf("chain_stall_%0d", i), {31'd0, b_stall}, 32'(i % 2));
      tick();
    end
    chk("sat_cnt_a", {16'd0, a_cnt}, 32'd6);
    chk("sat_cnt_b", {30'd0, b_cnt}, 32'd3);

    // Asynchronous reset mid-stream.
    tick();
    chk("pre_rst_valid", {31'd0, a_valid}, 32'd1);
    Rst_n = 1'b0;
    #1;
    chk("arst_valid",    {31'd0, a_valid},    32'd0);
    chk("arst_memtoreg", {31'd0, a_memtoreg}, 32'd0);
    chk("arst_cnt_a",    {16'd0, a_cnt},      32'd0);
    chk("arst_cnt_b",    {30'd0, b_cnt},      32'd0);
    chk("arst_stall",    {31'd0, a_stall},    32'd0);
    tick();
    Rst_n = 1'b1;
    drive(1'b1, 32'h0000_0040, ADD_R3_R5_R0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("post_rst_valid",  {31'd0, a_valid}, 32'd1);
    chk("post_rst_busa_a", a_busa,           32'd0);
    chk("post_rst_busa_b", b_busa,           32'd0);
    chk("post_rst_pc4",    a_pc4,            32'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
